// File: rtl/plic_reg_ext.sv
// plic_reg_ext: PLIC register file and APB-side access controller.
// Holds per-source priority, per-target enable banks and thresholds, exposes the
// gateway pending bits, and turns claim-register reads/writes into one-shot
// claim/complete strobes. Every access takes two cycles (IDLE decode, RESP reply).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reg_addr/read/write/wdata     access request, held until reg_ready
//   reg_rdata, reg_ready          registered reply, reg_ready pulses in RESP
//   claim_valid/tgt, claim_src    claim strobe out, best source for that target in
//   complete_valid/src/tgt        completion strobe
//   int_pending                   gateway pending bits (bit 0 ignored)
//   cfg_int_prio/enable/threshold configuration vectors to gateways/arbiters
module plic_reg_ext #(
  parameter int unsigned SRC_N  = 1,
  parameter int unsigned TGT_N  = 1,
  parameter int unsigned PRIO_W = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [25:0]                   reg_addr,
  input  logic                          reg_read,
  input  logic                          reg_write,
  input  logic [31:0]                   reg_wdata,
  output logic [31:0]                   reg_rdata,
  output logic                          reg_ready,
  output logic                          claim_valid,
  output logic [4:0]                    claim_tgt,
  input  logic [9:0]                    claim_src,
  output logic                          complete_valid,
  output logic [9:0]                    complete_src,
  output logic [4:0]                    complete_tgt,
  input  logic [SRC_N:0]                int_pending,
  output logic [(SRC_N+1)*PRIO_W-1:0]   cfg_int_prio,
  output logic [TGT_N*(SRC_N+1)-1:0]    cfg_int_enable,
  output logic [TGT_N*PRIO_W-1:0]       cfg_threshold
);

  localparam int unsigned NW   = (SRC_N + 32) / 32;
  localparam int unsigned PADW = NW * 32;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e state_q, state_d;

  logic [PRIO_W-1:0] prio_q [1:SRC_N];
  logic [SRC_N:1]    en_q   [TGT_N];
  logic [PRIO_W-1:0] thr_q  [TGT_N];

  logic [31:0] rdata_q, rd_c;
  logic        ready_q;
  logic        wr_go, rd_go;

  // Address fields
  logic [9:0] word_a;
  logic [4:0] en_tgt, en_word, ctx_tgt;
  logic       aligned, ctx_ok;
  logic       hit_prio, hit_pend, hit_en, hit_thr, hit_clm;
  logic [PADW-1:0] pend_pad, en_pad;

  assign word_a  = reg_addr[11:2];
  assign en_tgt  = reg_addr[11:7];
  assign en_word = reg_addr[6:2];
  assign ctx_tgt = reg_addr[16:12];

  // Address decode; anything not hit is unmapped
  always_comb begin
    aligned  = (reg_addr[1:0] == 2'b00);
    hit_prio = aligned && (reg_addr[25:12] == 14'h0000) && (word_a != 10'd0)
               && (32'(word_a) <= SRC_N);
    hit_pend = aligned && (reg_addr[25:12] == 14'h0001) && (32'(word_a) < NW);
    hit_en   = aligned && (reg_addr[25:12] == 14'h0002) && (32'(en_tgt) < TGT_N)
               && (32'(en_word) < NW);
    ctx_ok   = (reg_addr[25:17] == 9'h010) && (32'(ctx_tgt) < TGT_N);
    hit_thr  = ctx_ok && (reg_addr[11:0] == 12'h000);
    hit_clm  = ctx_ok && (reg_addr[11:0] == 12'h004);
  end

  // Read mux; pending/enable banks are padded so unimplemented sources read 0
  always_comb begin
    pend_pad          = '0;
    pend_pad[SRC_N:0] = int_pending;
    pend_pad[0]       = 1'b0;
    en_pad            = '0;
    rd_c              = '0;
    if (hit_prio) begin
      for (int unsigned s = 1; s <= SRC_N; s++) begin
        if (word_a == 10'(s)) rd_c = 32'(prio_q[s]);
      end
    end
    if (hit_pend) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (word_a == 10'(w)) rd_c = pend_pad[w*32 +: 32];
      end
    end
    if (hit_en) begin
      for (int unsigned t = 0; t < TGT_N; t++) begin
        if (en_tgt == 5'(t)) begin
          en_pad          = '0;
          en_pad[SRC_N:0] = {en_q[t], 1'b0};
        end
      end
      for (int unsigned w = 0; w < NW; w++) begin
        if (en_word == 5'(w)) rd_c = en_pad[w*32 +: 32];
      end
    end
    if (hit_thr) begin
      for (int unsigned t = 0; t < TGT_N; t++) begin
        if (ctx_tgt == 5'(t)) rd_c = 32'(thr_q[t]);
      end
    end
    if (hit_clm) rd_c = 32'(claim_src);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and one-shot strobes; write wins when both strobes are set
  always_comb begin
    state_d        = state_q;
    wr_go          = 1'b0;
    rd_go          = 1'b0;
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_write) begin
          wr_go          = 1'b1;
          complete_valid = hit_clm && (reg_wdata[31:10] == 22'd0);
          state_d        = RESP;
        end else if (reg_read) begin
          rd_go       = 1'b1;
          claim_valid = hit_clm;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign claim_tgt    = ctx_tgt;
  assign complete_tgt = ctx_tgt;
  assign complete_src = reg_wdata[9:0];

  // Response registers; rdata holds until the next read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= wr_go | rd_go;
      if (rd_go) rdata_q <= rd_c;
    end
  end

  assign reg_ready = ready_q;
  assign reg_rdata = rdata_q;

  // Configuration registers, committed at the end of the IDLE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 1; s <= SRC_N; s++) prio_q[s] <= '0;
      for (int unsigned t = 0; t < TGT_N; t++) begin
        en_q[t]  <= '0;
        thr_q[t] <= '0;
      end
    end else if (wr_go) begin
      if (hit_prio) begin
        for (int unsigned s = 1; s <= SRC_N; s++) begin
          if (word_a == 10'(s)) prio_q[s] <= reg_wdata[PRIO_W-1:0];
        end
      end
      if (hit_en) begin
        for (int unsigned t = 0; t < TGT_N; t++) begin
          for (int unsigned s = 1; s <= SRC_N; s++) begin
            if ((en_tgt == 5'(t)) && (en_word == 5'(s / 32)))
              en_q[t][s] <= reg_wdata[s % 32];
          end
        end
      end
      if (hit_thr) begin
        for (int unsigned t = 0; t < TGT_N; t++) begin
          if (ctx_tgt == 5'(t)) thr_q[t] <= reg_wdata[PRIO_W-1:0];
        end
      end
    end
  end

  // Flatten configuration vectors; entry/bit 0 is always zero
  always_comb begin
    cfg_int_prio   = '0;
    cfg_int_enable = '0;
    cfg_threshold  = '0;
    for (int unsigned s = 1; s <= SRC_N; s++)
      cfg_int_prio[s*PRIO_W +: PRIO_W] = prio_q[s];
    for (int unsigned t = 0; t < TGT_N; t++) begin
      cfg_int_enable[t*(SRC_N+1) +: SRC_N+1] = {en_q[t], 1'b0};
      cfg_threshold[t*PRIO_W +: PRIO_W]      = thr_q[t];
    end
  end

endmodule

// File: tb/tb_plic_reg_ext.sv
// Scoreboard bench for plic_reg_ext (SRC_N=40, TGT_N=2, PRIO_W=3).
module tb_plic_reg_ext;
  localparam int unsigned SRC_N  = 40;
  localparam int unsigned TGT_N  = 2;
  localparam int unsigned PRIO_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [25:0] reg_addr = '0;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        claim_valid;
  logic [4:0]  claim_tgt;
  logic [9:0]  claim_src = '0;
  logic        complete_valid;
  logic [9:0]  complete_src;
  logic [4:0]  complete_tgt;
  logic [SRC_N:0] int_pending = '0;
  logic [(SRC_N+1)*PRIO_W-1:0] cfg_int_prio;
  logic [TGT_N*(SRC_N+1)-1:0]  cfg_int_enable;
  logic [TGT_N*PRIO_W-1:0]     cfg_threshold;

  int total = 0;
  int bad   = 0;

  bit          rsp_rd_q[$];
  logic [31:0] rsp_d_q[$];
  string       rsp_n_q[$];
  logic [4:0]  clm_q[$];
  logic [14:0] cmp_q[$];

  plic_reg_ext #(.SRC_N(SRC_N), .TGT_N(TGT_N), .PRIO_W(PRIO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_read(reg_read), .reg_write(reg_write),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .claim_valid(claim_valid), .claim_tgt(claim_tgt), .claim_src(claim_src),
    .complete_valid(complete_valid), .complete_src(complete_src),
    .complete_tgt(complete_tgt), .int_pending(int_pending),
    .cfg_int_prio(cfg_int_prio), .cfg_int_enable(cfg_int_enable),
    .cfg_threshold(cfg_threshold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a reply or strobe
  always @(negedge clk) begin
    if (reg_ready) begin
      total++;
      if (rsp_rd_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready rdata=%08h", reg_rdata);
      end else begin
        bit rd; logic [31:0] d; string nm;
        rd = rsp_rd_q.pop_front(); d = rsp_d_q.pop_front(); nm = rsp_n_q.pop_front();
        if (rd && reg_rdata !== d) begin
          bad++;
          $display("FAIL %s rdata actual=%08h required=%08h", nm, reg_rdata, d);
        end
      end
    end
    if (claim_valid) begin
      total++;
      if (clm_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_claim tgt=%0d", claim_tgt);
      end else begin
        logic [4:0] t;
        t = clm_q.pop_front();
        if (claim_tgt !== t) begin
          bad++;
          $display("FAIL claim_tgt actual=%0d required=%0d", claim_tgt, t);
        end
      end
    end
    if (complete_valid) begin
      total++;
      if (cmp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_complete src=%0d tgt=%0d", complete_src, complete_tgt);
      end else begin
        logic [14:0] c;
        c = cmp_q.pop_front();
        if ({complete_src, complete_tgt} !== c) begin
          bad++;
          $display("FAIL complete actual=%0h required=%0h", {complete_src, complete_tgt}, c);
        end
      end
    end
  end

  // Issue one access; returns during the RESP cycle with strobes still held
  task automatic access(input bit wr, input bit rd, input logic [25:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, input string nm);
    int n;
    rsp_rd_q.push_back(rd && !wr);
    rsp_d_q.push_back(exp);
    rsp_n_q.push_back(nm);
    @(posedge clk); #1;
    reg_addr = a; reg_write = wr; reg_read = rd; reg_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!reg_ready && n < 5);
    chk({nm, "_lat"}, 64'(n), 64'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    reg_read = 1'b0; reg_write = 1'b0;
  endtask

  initial begin
    int nready;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", 64'(reg_ready), 64'd0);
    chk("rst_rdata", 64'(reg_rdata), 64'd0);
    chk("rst_claim", 64'(claim_valid), 64'd0);
    chk("rst_complete", 64'(complete_valid), 64'd0);
    chk("rst_cfg_zero", 64'((cfg_int_prio == '0) && (cfg_int_enable == '0) && (cfg_threshold == '0)), 64'd1);

    access(0, 1, 26'h0000004, 0, 32'h0, "rd_prio1");
    access(0, 1, 26'h0002000, 0, 32'h0, "rd_en00");
    access(0, 1, 26'h0200000, 0, 32'h0, "rd_thr0");

    access(1, 0, 26'h00000A0, 32'hFF, 0, "wr_prio40");
    chk("cfg_prio40", 64'(cfg_int_prio[40*PRIO_W +: PRIO_W]), 64'd7);
    access(0, 1, 26'h00000A0, 0, 32'h7, "rd_prio40");
    access(0, 1, 26'h00000A4, 0, 32'h0, "rd_prio41_unmapped");

    access(1, 0, 26'h0002084, 32'hFFFFFFFF, 0, "wr_en11");
    chk("cfg_en1_hi", 64'(cfg_int_enable[(SRC_N+1)+32 +: 9]), 64'h1FF);
    access(0, 1, 26'h0002084, 0, 32'h000001FF, "rd_en11");
    access(1, 0, 26'h0002080, 32'hFFFFFFFF, 0, "wr_en10");
    access(0, 1, 26'h0002080, 0, 32'hFFFFFFFE, "rd_en10");
    access(0, 1, 26'h0002004, 0, 32'h0, "rd_en01");

    int_pending = '0;
    int_pending[35] = 1'b1;
    int_pending[1]  = 1'b1;
    int_pending[0]  = 1'b1;
    access(0, 1, 26'h0001004, 0, 32'h8, "rd_pend1");
    access(0, 1, 26'h0001000, 0, 32'h2, "rd_pend0");
    access(1, 0, 26'h0001004, 32'h0, 0, "wr_pend1");
    access(0, 1, 26'h0001004, 0, 32'h8, "rd_pend1_again");
    access(0, 1, 26'h0001008, 0, 32'h0, "rd_pend2_unmapped");

    access(1, 0, 26'h0201000, 32'hD, 0, "wr_thr1");
    chk("cfg_thr1", 64'(cfg_threshold[PRIO_W +: PRIO_W]), 64'd5);
    access(0, 1, 26'h0201000, 0, 32'h5, "rd_thr1");
    access(0, 1, 26'h0202000, 0, 32'h0, "rd_thr2_unmapped");

    claim_src = 10'd17;
    clm_q.push_back(5'd1);
    access(0, 1, 26'h0201004, 0, 32'd17, "claim1");

    cmp_q.push_back({10'd17, 5'd1});
    access(1, 0, 26'h0201004, 32'd17, 0, "complete17");
    access(1, 0, 26'h0201004, 32'h400, 0, "complete_bad_data");
    access(1, 0, 26'h0202004, 32'd3, 0, "complete_bad_tgt");
    cmp_q.push_back({10'd5, 5'd1});
    access(1, 1, 26'h0201004, 32'd5, 0, "both_strobes");

    // Reset during the IDLE cycle of a read
    idle();
    reg_addr = 26'h0000004; reg_read = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1 reg_read = 1'b0;
    nready = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (reg_ready) nready++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (reg_ready) nready++;
    end
    chk("rst_mid_no_ready", 64'(nready), 64'd0);
    chk("rst_mid_rdata", 64'(reg_rdata), 64'd0);
    chk("rst_mid_cfg_zero", 64'((cfg_int_prio == '0) && (cfg_int_enable == '0) && (cfg_threshold == '0)), 64'd1);

    repeat (3) @(posedge clk);
    chk("rsp_left", 64'(rsp_rd_q.size()), 64'd0);
    chk("claim_left", 64'(clm_q.size()), 64'd0);
    chk("complete_left", 64'(cmp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
